// File: rtl/gpu_bg_pair_reader_if.sv
// gpu_bg_pair_reader_if: request, VRAM read and pixel-pair output channels of the BG pair reader
interface gpu_bg_pair_reader_if;
  logic i_req_valid, o_req_ready, i_req_needBG;
  logic [9:0] i_req_scrX_Mul2;
  logic [8:0] i_req_scrY;
  logic o_mem_rd_valid, i_mem_rd_ready, i_mem_data_valid;
  logic [17:0] o_mem_rd_addr;
  logic [31:0] i_mem_data;
  logic o_pix_valid, i_pix_ready;
  logic [4:0] o_rBG_L, o_gBG_L, o_bBG_L, o_rBG_R, o_gBG_R, o_bBG_R;
  logic o_bgMskL, o_bgMskR, o_protoErr;
  logic [9:0] o_scrX_Mul2;
  logic [8:0] o_scrY;
  modport slave (
    input i_req_valid, i_req_scrX_Mul2, i_req_scrY, i_req_needBG, i_mem_rd_ready,
          i_mem_data_valid, i_mem_data, i_pix_ready,
    output o_req_ready, o_mem_rd_valid, o_mem_rd_addr, o_pix_valid,
           o_rBG_L, o_gBG_L, o_bBG_L, o_rBG_R, o_gBG_R, o_bBG_R,
           o_bgMskL, o_bgMskR, o_scrX_Mul2, o_scrY, o_protoErr
  );
  modport master (
    output i_req_valid, i_req_scrX_Mul2, i_req_scrY, i_req_needBG, i_mem_rd_ready,
           i_mem_data_valid, i_mem_data, i_pix_ready,
    input o_req_ready, o_mem_rd_valid, o_mem_rd_addr, o_pix_valid,
          o_rBG_L, o_gBG_L, o_bBG_L, o_rBG_R, o_gBG_R, o_bBG_R,
          o_bgMskL, o_bgMskR, o_scrX_Mul2, o_scrY, o_protoErr
  );
endinterface

// File: rtl/gpu_bg_pair_reader.sv
// gpu_bg_pair_reader: in-order VRAM background fetch and unpack for screen pixel pairs
module gpu_bg_pair_reader #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic i_nrst,
  gpu_bg_pair_reader_if.slave bus
);
  localparam int PW = CNT_W - 1;
  logic [9:0] tagX [DEPTH];
  logic [8:0] tagY [DEPTH];
  logic [DEPTH-1:0] tagNeed;
  logic [31:0] dat [DEPTH];
  logic [PW-1:0] tagWr, tagRd, datWr, datRd;
  logic [CNT_W-1:0] tagCnt, rdOut, datCnt;
  logic space, accept, issue, ret, pop, popDat, headNeed;
  logic [31:0] w;
  assign space = tagCnt < CNT_W'(DEPTH);
  // ready and read-valid are forced low while reset is asserted
  assign bus.o_mem_rd_valid = i_nrst & bus.i_req_valid & bus.i_req_needBG & space;
  assign bus.o_mem_rd_addr = {bus.i_req_scrY, bus.i_req_scrX_Mul2[9:1]};
  assign bus.o_req_ready = i_nrst & space & (!bus.i_req_needBG | bus.i_mem_rd_ready);
  assign accept = bus.i_req_valid & bus.o_req_ready;
  assign issue = accept & bus.i_req_needBG;
  assign ret = bus.i_mem_data_valid & (rdOut != '0);
  assign headNeed = tagNeed[tagRd];
  assign bus.o_pix_valid = (tagCnt != '0) & (!headNeed | (datCnt != '0));
  assign pop = bus.o_pix_valid & bus.i_pix_ready;
  assign popDat = pop & headNeed;
  assign w = headNeed ? dat[datRd] : '0;
  assign bus.o_rBG_L = w[4:0];
  assign bus.o_gBG_L = w[9:5];
  assign bus.o_bBG_L = w[14:10];
  assign bus.o_bgMskL = w[15];
  assign bus.o_rBG_R = w[20:16];
  assign bus.o_gBG_R = w[25:21];
  assign bus.o_bBG_R = w[30:26];
  assign bus.o_bgMskR = w[31];
  assign bus.o_scrX_Mul2 = tagX[tagRd];
  assign bus.o_scrY = tagY[tagRd];
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      tagX <= '{default: '0};
      tagY <= '{default: '0};
      dat <= '{default: '0};
      tagNeed <= '0;
      tagWr <= '0;
      tagRd <= '0;
      datWr <= '0;
      datRd <= '0;
      tagCnt <= '0;
      rdOut <= '0;
      datCnt <= '0;
      bus.o_protoErr <= 1'b0;
    end else begin
      if (accept) begin
        tagX[tagWr] <= bus.i_req_scrX_Mul2;
        tagY[tagWr] <= bus.i_req_scrY;
        tagNeed[tagWr] <= bus.i_req_needBG;
        tagWr <= tagWr + 1'b1;
      end
      if (pop) tagRd <= tagRd + 1'b1;
      if (ret) begin
        dat[datWr] <= bus.i_mem_data;
        datWr <= datWr + 1'b1;
      end
      if (popDat) datRd <= datRd + 1'b1;
      tagCnt <= tagCnt + CNT_W'(accept) - CNT_W'(pop);
      rdOut <= rdOut + CNT_W'(issue) - CNT_W'(ret);
      datCnt <= datCnt + CNT_W'(ret) - CNT_W'(popDat);
      if (bus.i_mem_data_valid & (rdOut == '0)) bus.o_protoErr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gpu_bg_pair_reader.sv
// tb_gpu_bg_pair_reader: directed and randomized checks against a queue-level model
module tb_gpu_bg_pair_reader;
  logic clk = 1'b0;
  logic i_nrst = 1'b1;
  always #5 clk = ~clk;
  gpu_bg_pair_reader_if bus();
  gpu_bg_pair_reader #(.DEPTH(4), .CNT_W(3)) dut (.clk(clk), .i_nrst(i_nrst), .bus(bus));
  typedef struct {logic [9:0] x; logic [8:0] y; bit need; bit has; logic [31:0] w;} ent_t;
  typedef struct {logic [31:0] w; int due;} mem_t;
  ent_t mq[$];
  mem_t mp[$];
  bit expErr, autoMem, lastAcc;
  int cyc, lastDue, tests, fails;
  logic reqValid, reqNeed, rdReady, pixReady, dValid;
  logic [9:0] reqX;
  logic [8:0] reqY;
  logic [31:0] dWord;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] pack(ent_t e);
    logic [31:0] v = e.need ? e.w : 32'd0;
    return {13'd0, 5'(v % 32), 5'((v >> 5) % 32), 5'((v >> 10) % 32),
            5'((v >> 16) % 32), 5'((v >> 21) % 32), 5'((v >> 26) % 32),
            1'((v >> 15) % 2), 1'((v >> 31) % 2), e.x, e.y};
  endfunction
  function automatic logic [63:0] dutPix();
    return {13'd0, bus.o_rBG_L, bus.o_gBG_L, bus.o_bBG_L, bus.o_rBG_R, bus.o_gBG_R, bus.o_bBG_R,
            bus.o_bgMskL, bus.o_bgMskR, bus.o_scrX_Mul2, bus.o_scrY};
  endfunction
  task automatic drive();
    bus.i_req_valid = reqValid;
    bus.i_req_scrX_Mul2 = reqX;
    bus.i_req_scrY = reqY;
    bus.i_req_needBG = reqNeed;
    bus.i_mem_rd_ready = rdReady;
    bus.i_pix_ready = pixReady;
    bus.i_mem_data_valid = dValid;
    bus.i_mem_data = dWord;
  endtask
  task automatic step();
    bit space, expRdy, expValid, acc, pop, ret;
    ent_t e;
    mem_t m;
    if (autoMem) begin
      dValid = mp.size() > 0 && mp[0].due <= cyc;
      dWord = dValid ? mp[0].w : $urandom;
    end
    drive();
    #1;
    space = mq.size() < 4;
    expRdy = space && (!reqNeed || rdReady);
    expValid = mq.size() > 0 && (!mq[0].need || mq[0].has);
    check("req_ready", bus.o_req_ready, expRdy);
    check("mem_rd_valid", bus.o_mem_rd_valid, reqValid && reqNeed && space);
    if (reqValid && reqNeed && space)
      check("mem_rd_addr", bus.o_mem_rd_addr, 64'(reqY) * 512 + 64'(reqX) / 2);
    check("pix_valid", bus.o_pix_valid, expValid);
    if (expValid) check("pix_fields", dutPix(), pack(mq[0]));
    check("protoErr", bus.o_protoErr, expErr);
    acc = reqValid && expRdy;
    pop = expValid && pixReady;
    if (dValid) begin
      ret = 0;
      foreach (mq[i]) if (!ret && mq[i].need && !mq[i].has) begin
        mq[i].has = 1;
        mq[i].w = dWord;
        ret = 1;
      end
      if (!ret) expErr = 1;
      if (autoMem) void'(mp.pop_front());
    end
    if (pop) void'(mq.pop_front());
    if (acc) begin
      e = '{reqX, reqY, reqNeed, 1'b0, 32'd0};
      mq.push_back(e);
      if (reqNeed && autoMem) begin
        lastDue = (lastDue + 1 > cyc + 1 + int'($urandom_range(0, 4))) ? lastDue + 1 : cyc + 1 + int'($urandom_range(0, 4));
        m = '{$urandom, lastDue};
        mp.push_back(m);
      end
    end
    lastAcc = acc;
    @(negedge clk);
    cyc++;
  endtask
  task automatic doReset();
    i_nrst = 1'b0;
    #1;
    check("rst_pix_valid", bus.o_pix_valid, 0);
    check("rst_protoErr", bus.o_protoErr, 0);
    check("rst_req_ready", bus.o_req_ready, 0);
    check("rst_mem_rd_valid", bus.o_mem_rd_valid, 0);
    check("rst_fields", dutPix(), 0);
    mq.delete();
    mp.delete();
    expErr = 0;
    lastDue = 0;
    lastAcc = 0;
    @(negedge clk);
    cyc++;
    i_nrst = 1'b1;
  endtask
  task automatic req(input logic v, input logic [9:0] x, input logic [8:0] y, input logic n);
    reqValid = v;
    reqX = x;
    reqY = y;
    reqNeed = n;
  endtask
  initial begin
    autoMem = 0;
    req(1, 10'h3ff, 9'h1ff, 1);
    rdReady = 1;
    pixReady = 1;
    dValid = 0;
    dWord = 0;
    drive();
    #1;
    doReset();
    // single fetch with the documented word and address
    req(1, 10'h006, 9'd3, 1);
    drive();
    #1;
    check("fetch_addr", bus.o_mem_rd_addr, 18'h00603);
    step();
    req(0, 0, 0, 0);
    step();
    dValid = 1;
    dWord = 32'h8421_7FFF;
    step();
    dValid = 0;
    drive();
    #1;
    check("fetch_valid", bus.o_pix_valid, 1);
    check("fetch_fields", dutPix(), {13'd0, 5'd31, 5'd31, 5'd31, 5'd1, 5'd1, 5'd1, 1'b0, 1'b1, 10'h006, 9'd3});
    step();
    step();
    // bypass waits behind an earlier fetch
    req(1, 10'h010, 9'd5, 1);
    step();
    req(1, 10'h012, 9'd5, 0);
    step();
    req(0, 0, 0, 0);
    repeat (5) step();
    dValid = 1;
    dWord = $urandom;
    step();
    dValid = 0;
    step();
    drive();
    #1;
    check("bypass_valid", bus.o_pix_valid, 1);
    check("bypass_fields", dutPix(), {45'd0, 10'h012, 9'd5});
    step();
    // fill to DEPTH, then pop and push together while full
    pixReady = 0;
    for (int i = 0; i < 5; i++) begin
      req(1, 10'(i * 2 + 40), 9'(i + 7), 1);
      step();
    end
    req(0, 0, 0, 0);
    dValid = 1;
    for (int i = 0; i < 4; i++) begin
      dWord = $urandom;
      step();
    end
    dValid = 0;
    req(1, 10'h020, 9'd9, 0);
    pixReady = 1;
    drive();
    #1;
    check("full_ready", bus.o_req_ready, 0);
    step();
    pixReady = 0;
    step();
    req(0, 0, 0, 0);
    pixReady = 1;
    repeat (6) step();
    // read backpressure blocks fetches but not bypasses
    rdReady = 0;
    req(1, 10'h100, 9'd20, 1);
    step();
    req(0, 0, 0, 0);
    step();
    req(1, 10'h102, 9'd20, 0);
    step();
    req(0, 0, 0, 0);
    repeat (2) step();
    rdReady = 1;
    // stray data with nothing outstanding
    dValid = 1;
    dWord = 32'hdead_beef;
    step();
    dValid = 0;
    repeat (2) step();
    doReset();
    // reset with tags and data in flight
    pixReady = 0;
    for (int i = 0; i < 3; i++) begin
      req(1, 10'(i * 2 + 100), 9'(i + 50), 1);
      step();
    end
    req(0, 0, 0, 0);
    dValid = 1;
    dWord = $urandom;
    step();
    dValid = 0;
    step();
    #2;
    doReset();
    pixReady = 1;
    req(1, 10'h0aa, 9'd77, 0);
    step();
    req(0, 0, 0, 0);
    step();
    step();
    // randomized traffic with an in-order memory of random latency
    autoMem = 1;
    for (int c = 0; c < 1500; c++) begin
      if (!(reqValid && !lastAcc)) req($urandom % 2, 10'($urandom), 9'($urandom), $urandom % 2);
      rdReady = ($urandom % 4) != 0;
      pixReady = ($urandom % 3) != 0;
      step();
    end
    req(0, 0, 0, 0);
    rdReady = 1;
    pixReady = 1;
    repeat (30) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpu_bg_pair_reader.md
Name: gpu_bg_pair_reader

Overview:
- Read-side counterpart of the GPU pixel-pair compute/write path.
- Accepts background-fetch requests for a screen pixel pair (X*2, Y) and issues 32-bit VRAM word reads.
- Unpacks each returned word into left/right 5-bit R/G/B channels and bit-15 mask flags, in the exact form the compute stage consumes as BG inputs.
- Keeps results in request order through a tag FIFO and a data FIFO, and presents them over a valid/ready handshake.

Parameters:
- DEPTH, 4, maximum requests in flight, tag and data FIFO depth (power of 2, ≥2).
- CNT_W, 3, width of occupancy counters; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  single clock, rising edge.
- i_nrst  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted when valid&ready.
- i_req_scrX_Mul2  in  10  screen X of pair (bit0 ignored).
- i_req_scrY  in  9  screen Y.
- i_req_needBG  in  1  1 = fetch from VRAM; 0 = bypass, returns zero BG.
- o_mem_rd_valid  out  1  VRAM read request.
- i_mem_rd_ready  in  1  VRAM accepts read.
- o_mem_rd_addr  out  18  word address {scrY[8:0], scrX_Mul2[9:1]}.
- i_mem_data_valid  in  1  read data returned (in-order, 1 word per read).
- i_mem_data  in  32  {mskR,bR,gR,rR, mskL,bL,gL,rL}, 1+5+5+5 per pixel.
- o_pix_valid  out  1  unpacked pair available.
- i_pix_ready  in  1  consumer takes pair.
- o_rBG_L,o_gBG_L,o_bBG_L,o_rBG_R,o_gBG_R,o_bBG_R  out  5 each  unpacked channels.
- o_bgMskL, o_bgMskR  out  1 each  bit15 of left/right pixel.
- o_scrX_Mul2  out  10  echo of request X.
- o_scrY  out  9  echo of request Y.
- o_protoErr  out  1  sticky: data returned with no read outstanding.

Behaviour:
- Reset (i_nrst=0, async): FIFOs empty, counters 0, o_req_ready=0 during reset, o_pix_valid=0, o_mem_rd_valid=0, o_protoErr=0, all data outputs 0.
- Reset mid-operation discards all tags and data; the memory side must be reset in the same domain.
- tagCnt: entries in the tag FIFO. rdOut: reads issued and not yet returned. datCnt: entries in the data FIFO.
- space = (tagCnt < DEPTH). Push while full is refused even when a pop happens in the same cycle.
- o_mem_rd_valid = i_req_valid & i_req_needBG & space (combinational).
- o_req_ready = space & (!i_req_needBG | i_mem_rd_ready).
- Accept: push tag {x, y, needBG}. If needBG=1, the read issues in the same cycle and rdOut increments.
- Data return: when i_mem_data_valid and rdOut>0, push the word into the data FIFO and decrement rdOut.
  - If rdOut=0: drop the word and set o_protoErr (held until reset).
  - Issue and return in the same cycle leave rdOut unchanged.
- Data FIFO cannot overflow because rdOut+datCnt ≤ tagCnt ≤ DEPTH.
- o_pix_valid = tagCnt>0 & (!headTag.needBG | datCnt>0).
- Pop on o_pix_valid & i_pix_ready: pop the tag, and pop the data only if headTag.needBG=1.
- Output fields come from the head entries, combinationally from FIFO storage.
  - needBG=0: all channels and masks are 0; x/y are echoed.
  - Unpack rule: r=w[4:0], g=w[9:5], b=w[14:10], msk=w[15] for L; the same fields at +16 for R.
- Latency:
  - Bypass request accepted at cycle N → o_pix_valid at N+1.
  - Memory word at cycle M → o_pix_valid at M+1, provided older entries have drained.
- Order: outputs always leave in request-acceptance order. Bypass entries wait behind earlier pending reads.
- Pointers wrap modulo DEPTH. Counters saturate only by construction and never exceed DEPTH.
- Inputs must be held stable while valid & !ready; outputs are held stable while o_pix_valid & !i_pix_ready.

Test Plan:
- Single fetch: req X2=0x006,Y=3,needBG=1; mem returns 0x8421_7FFF two cycles later → o_mem_rd_addr=0x00603. Output: rL=gL=bL=31, mskL=0; rR=1, gR=1, bR=1, mskR=1; valid one cycle after data.
- Bypass ordering: fetch A then bypass B; delay A's data 5 cycles → B is not presented before A; B has all channels 0; valid the cycle after A pops.
- Full: i_pix_ready=0, i_mem_rd_ready=1, issue DEPTH=4 fetches → o_req_ready=0 on the 5th. A pop and a push in the same cycle while full → push refused, tagCnt=3 next cycle.
- Backpressure: i_mem_rd_ready=0 with needBG=1 → o_req_ready=0 and no tag pushed. Bypass requests are still accepted while i_mem_rd_ready=0.
- Protocol error: i_mem_data_valid pulsed with rdOut=0 → o_protoErr=1 and stays 1, no output produced. Assert i_nrst=0 → o_protoErr=0.
- Async reset mid-stream: 3 tags and 1 data held, then reset → o_pix_valid=0 immediately. After release, a new bypass request yields output at N+1 with no stale data.
